// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB pipeline register with load extraction and write-back select
module mem_wb_stage #(
  parameter logic [31:0] WB_PC_OFFSET = 32'd8,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      PC_M,
  input  logic [31:0]      Instr_M,
  input  logic [31:0]      ALUOut_M,
  input  logic [31:0]      MD_M,
  input  logic [4:0]       WriteReg_M,
  input  logic             RegWrite_M,
  input  logic [1:0]       WDSel_M,
  output logic [31:0]      PC_W,
  output logic [31:0]      Instr_W,
  output logic [4:0]       WriteReg_W,
  output logic             RegWrite_W,
  output logic [31:0]      WD_W,
  output logic             valid_W,
  output logic             align_err_W,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  logic [31:0] alu_w;
  logic [31:0] md_w;
  logic [1:0]  wdsel_w;
  logic        regwrite_r;
  logic [5:0]  op;
  logic [1:0]  ofs;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        leaving;

  assign op  = Instr_W[31:26];
  assign ofs = alu_w[1:0];

  // An instruction leaves W on any edge that is not a pure stall (flush overrides stall).
  assign leaving = valid_W & (flush | ~stall);

  // W register bank: flush inserts a bubble, stall holds, otherwise capture MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_W       <= '0;
      Instr_W    <= '0;
      alu_w      <= '0;
      md_w       <= '0;
      WriteReg_W <= '0;
      regwrite_r <= 1'b0;
      wdsel_w    <= '0;
      valid_W    <= 1'b0;
    end else if (flush) begin
      PC_W       <= '0;
      Instr_W    <= '0;
      alu_w      <= '0;
      md_w       <= '0;
      WriteReg_W <= '0;
      regwrite_r <= 1'b0;
      wdsel_w    <= '0;
      valid_W    <= 1'b0;
    end else if (!stall) begin
      PC_W       <= PC_M;
      Instr_W    <= Instr_M;
      alu_w      <= ALUOut_M;
      md_w       <= MD_M;
      WriteReg_W <= WriteReg_M;
      regwrite_r <= RegWrite_M;
      wdsel_w    <= WDSel_M;
      valid_W    <= 1'b1;
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
    end else if (leaving) begin
      retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pick the addressed half-word and byte out of the memory word.
  always_comb begin
    half_sel = ofs[1] ? md_w[31:16] : md_w[15:0];
    case (ofs)
      2'b00:   byte_sel = md_w[7:0];
      2'b01:   byte_sel = md_w[15:8];
      2'b10:   byte_sel = md_w[23:16];
      default: byte_sel = md_w[31:24];
    endcase
  end

  // Write-back data select with load extension; reserved select falls back to ALU.
  always_comb begin
    WD_W = alu_w;
    case (wdsel_w)
      2'b01: begin
        case (op)
          OP_LH:   WD_W = {{16{half_sel[15]}}, half_sel};
          OP_LHU:  WD_W = {16'h0000, half_sel};
          OP_LB:   WD_W = {{24{byte_sel[7]}}, byte_sel};
          OP_LBU:  WD_W = {24'h000000, byte_sel};
          default: WD_W = md_w;
        endcase
      end
      2'b10:   WD_W = PC_W + WB_PC_OFFSET;
      default: WD_W = alu_w;
    endcase
  end

  // Misaligned loads are flagged only; data is still produced as if aligned.
  always_comb begin
    align_err_W = valid_W & (((op == OP_LW) & (ofs != 2'b00)) |
                             (((op == OP_LH) | (op == OP_LHU)) & ofs[0]));
    RegWrite_W  = valid_W & regwrite_r & (WriteReg_W != 5'd0);
  end

endmodule
